// File: rtl/switch_debounce_if.sv
// Switch bus between the raw slide-switch source and the debouncer.
// The master side drives enable and raw levels; the slave side returns clean levels and edge pulses.
interface switch_debounce_if #(
    parameter int NUM_SWITCHES = 2
);
    logic                    i_enable;
    logic [NUM_SWITCHES-1:0] i_switch;
    logic [NUM_SWITCHES-1:0] o_switch;
    logic [NUM_SWITCHES-1:0] o_rise;
    logic [NUM_SWITCHES-1:0] o_fall;

    modport master (
        output i_enable,
        output i_switch,
        input  o_switch,
        input  o_rise,
        input  o_fall
    );

    modport slave (
        input  i_enable,
        input  i_switch,
        output o_switch,
        output o_rise,
        output o_fall
    );
endinterface

// File: rtl/switch_debounce.sv
// Per-channel synchroniser + stability counter + STABLE/COUNTING FSM; SWITCH_DEBOUNCE_EDGE_EN adds o_rise/o_fall pulses.
// Latency: a held level reaches o_switch on edge SYNC_STAGES+DEBOUNCE_CYCLES; pulses coincide with the new level.
// No backpressure: i_enable low freezes outputs and clears qualification, synchronisers keep running.
module switch_debounce #(
    parameter int NUM_SWITCHES    = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    switch_debounce_if.slave   sw_bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0]  sync_q  [NUM_SWITCHES];
    logic [NUM_SWITCHES-1:0] sync;
    state_t                  state_q [NUM_SWITCHES];
    state_t                  state_d [NUM_SWITCHES];
    logic [CW-1:0]           cnt_q   [NUM_SWITCHES];
    logic [CW-1:0]           cnt_d   [NUM_SWITCHES];
    logic [NUM_SWITCHES-1:0] level_q;
    logic [NUM_SWITCHES-1:0] level_d;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int n = 0; n < NUM_SWITCHES; n++) begin
                sync_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_SWITCHES; n++) begin
                sync_q[n] <= {sync_q[n][SYNC_STAGES-2:0], sw_bus.i_switch[n]};
            end
        end
    end

    always_comb begin
        sync = '0;
        for (int n = 0; n < NUM_SWITCHES; n++) begin
            sync[n] = sync_q[n][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            level_q <= '0;
            for (int n = 0; n < NUM_SWITCHES; n++) begin
                state_q[n] <= STABLE;
                cnt_q[n]   <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int n = 0; n < NUM_SWITCHES; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    always_comb begin
        level_d = level_q;
        for (int n = 0; n < NUM_SWITCHES; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            if (!sw_bus.i_enable) begin
                state_d[n] = STABLE;
                cnt_d[n]   = '0;
            end else begin
                case (state_q[n])
                    STABLE: begin
                        cnt_d[n] = '0;
                        if (sync[n] != level_q[n]) begin
                            state_d[n] = COUNTING;
                            cnt_d[n]   = CNT_ONE;
                        end
                    end
                    COUNTING: begin
                        // Any bounce back to the current level restarts the full qualification.
                        if (sync[n] == level_q[n]) begin
                            state_d[n] = STABLE;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == CNT_MAX) begin
                            level_d[n] = ~level_q[n];
                            state_d[n] = STABLE;
                            cnt_d[n]   = '0;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[n] = STABLE;
                        cnt_d[n]   = '0;
                    end
                endcase
            end
        end
    end

    assign sw_bus.o_switch = level_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [NUM_SWITCHES-1:0] rise_q;
    logic [NUM_SWITCHES-1:0] fall_q;

    // Registered alongside level_q so each pulse lines up with the first cycle of the new level.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= level_d & ~level_q;
            fall_q <= ~level_d & level_q;
        end
    end

    assign sw_bus.o_rise = rise_q;
    assign sw_bus.o_fall = fall_q;
`else
    assign sw_bus.o_rise = '0;
    assign sw_bus.o_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce: a sliding-window reference model checked every cycle, plus literal expectations per phase.
module tb_switch_debounce;
    localparam int D = 4;
    localparam int S = 2;
    localparam int N = 2;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam logic [1:0] P01 = EDGE ? 2'b01 : 2'b00;
    localparam logic [1:0] P11 = EDGE ? 2'b11 : 2'b00;

    localparam int PH_RESET  = 0;
    localparam int PH_BASIC  = 1;
    localparam int PH_GLITCH = 2;
    localparam int PH_SETTLE = 3;
    localparam int PH_BOUNCE = 4;
    localparam int PH_FREEZE = 5;
    localparam int PH_RSTA   = 6;
    localparam int PH_RSTLOW = 7;
    localparam int PH_RSTREL = 8;

    logic clk;
    logic rst_n;
    int   phase;
    int   tests;
    int   fails;

    switch_debounce_if #(.NUM_SWITCHES(N)) bus ();

    switch_debounce #(
        .NUM_SWITCHES   (N),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .sw_bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Model: a channel flips when the synchronised level (raw delayed S edges) has differed
    // from the output on each of the last D enabled edges since reset.
    logic [N-1:0] raw_h [0:4095];
    bit           en_h  [0:4095];
    int           k;
    logic [N-1:0] m_sw, m_rise, m_fall;

    initial begin
        k = 0; m_sw = '0; m_rise = '0; m_fall = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; m_sw = '0; m_rise = '0; m_fall = '0;
            end else if (k < 4095) begin
                k++;
                raw_h[k] = bus.i_switch;
                en_h[k]  = bus.i_enable;
                m_rise = '0;
                m_fall = '0;
                for (int n = 0; n < N; n++) begin
                    bit flip;
                    flip = (k >= D);
                    for (int i = 0; i < D; i++) begin
                        int   j;
                        logic seen;
                        j = k - i;
                        if (j < 1) begin
                            flip = 1'b0;
                        end else begin
                            seen = (j - S >= 1) ? raw_h[j-S][n] : 1'b0;
                            if (!en_h[j] || seen == m_sw[n]) flip = 1'b0;
                        end
                    end
                    if (flip) begin
                        m_sw[n] = ~m_sw[n];
                        if (EDGE) begin
                            if (m_sw[n]) m_rise[n] = 1'b1;
                            else         m_fall[n] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        int         ph;
        int         off;
        logic [1:0] sw;
        logic [1:0] rise;
        logic [1:0] fall;
    } dir_t;
    dir_t dirs[$];
    int   last_ph;
    int   off;

    task automatic add(input int ph, input int o, input logic [1:0] sw,
                       input logic [1:0] r, input logic [1:0] f);
        dir_t d;
        d.ph = ph; d.off = o; d.sw = sw; d.rise = r; d.fall = f;
        dirs.push_back(d);
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s phase=%0d edge=%0d got=%b expected=%b", name, phase, off, got, exp);
        end
    endtask

    initial begin
        tests = 0; fails = 0; last_ph = -1; off = 0;
        add(PH_RESET,  1,  2'b00, 2'b00, 2'b00);
        add(PH_RESET,  3,  2'b00, 2'b00, 2'b00);
        add(PH_BASIC,  5,  2'b00, 2'b00, 2'b00);
        add(PH_BASIC,  6,  2'b01, P01,   2'b00);
        add(PH_BASIC,  7,  2'b01, 2'b00, 2'b00);
        add(PH_GLITCH, 6,  2'b01, 2'b00, 2'b00);
        add(PH_GLITCH, 8,  2'b01, 2'b00, 2'b00);
        add(PH_SETTLE, 5,  2'b01, 2'b00, 2'b00);
        add(PH_SETTLE, 6,  2'b00, 2'b00, P01);
        add(PH_SETTLE, 7,  2'b00, 2'b00, 2'b00);
        add(PH_BOUNCE, 6,  2'b00, 2'b00, 2'b00);
        add(PH_BOUNCE, 9,  2'b00, 2'b00, 2'b00);
        add(PH_BOUNCE, 10, 2'b01, P01,   2'b00);
        add(PH_BOUNCE, 11, 2'b01, 2'b00, 2'b00);
        add(PH_FREEZE, 5,  2'b01, 2'b00, 2'b00);
        add(PH_FREEZE, 10, 2'b01, 2'b00, 2'b00);
        add(PH_FREEZE, 13, 2'b01, 2'b00, 2'b00);
        add(PH_FREEZE, 14, 2'b00, 2'b00, P01);
        add(PH_FREEZE, 15, 2'b00, 2'b00, 2'b00);
        add(PH_RSTA,   4,  2'b00, 2'b00, 2'b00);
        add(PH_RSTLOW, 1,  2'b00, 2'b00, 2'b00);
        add(PH_RSTLOW, 2,  2'b00, 2'b00, 2'b00);
        add(PH_RSTREL, 5,  2'b00, 2'b00, 2'b00);
        add(PH_RSTREL, 6,  2'b11, P11,   2'b00);
        add(PH_RSTREL, 7,  2'b11, 2'b00, 2'b00);
        forever begin
            @(negedge clk);
            if (phase != last_ph) begin
                last_ph = phase;
                off = 1;
            end else begin
                off++;
            end
            chk("model_switch", bus.o_switch, m_sw);
            chk("model_rise",   bus.o_rise,   m_rise);
            chk("model_fall",   bus.o_fall,   m_fall);
            foreach (dirs[i]) begin
                if (dirs[i].ph == phase && dirs[i].off == off) begin
                    chk("lit_switch", bus.o_switch, dirs[i].sw);
                    chk("lit_rise",   bus.o_rise,   dirs[i].rise);
                    chk("lit_fall",   bus.o_fall,   dirs[i].fall);
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_switch = 2'b01;
        phase = PH_RESET;
        wait_neg(4);

        rst_n = 1'b1; phase = PH_BASIC;
        wait_neg(10);

        bus.i_switch = 2'b11; phase = PH_GLITCH;
        wait_neg(3);
        bus.i_switch = 2'b01;
        wait_neg(8);

        bus.i_switch = 2'b00; phase = PH_SETTLE;
        wait_neg(9);

        bus.i_switch = 2'b01; phase = PH_BOUNCE;
        wait_neg(1); bus.i_switch = 2'b00;
        wait_neg(1); bus.i_switch = 2'b01;
        wait_neg(1); bus.i_switch = 2'b00;
        wait_neg(1); bus.i_switch = 2'b01;
        wait_neg(10);

        bus.i_switch = 2'b00; phase = PH_FREEZE;
        wait_neg(5);
        bus.i_enable = 1'b0;
        wait_neg(5);
        bus.i_enable = 1'b1;
        wait_neg(8);

        bus.i_switch = 2'b11; phase = PH_RSTA;
        wait_neg(4);
        @(posedge clk);
        #5;
        rst_n = 1'b0; phase = PH_RSTLOW;
        wait_neg(2);
        rst_n = 1'b1; phase = PH_RSTREL;
        wait_neg(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
